// File: rtl/cpu6_alu_exu_pkg.sv
// Shared constants, operation/state encodings and small helpers for the cpu6 execute ALU.
package cpu6_alu_exu_pkg;

   localparam int XLEN                 = 32;
   localparam int SHAMT_W              = 5;
   localparam int CPU6_ALUCONTROL_SIZE = 4;

   // Operation codes as produced by the ALU decoder; shifts sit above the single-cycle ops.
   typedef enum logic [CPU6_ALUCONTROL_SIZE-1:0] {
      CPU6_ALUCONTROL_ADD = 4'd0,
      CPU6_ALUCONTROL_SUB = 4'd1,
      CPU6_ALUCONTROL_AND = 4'd2,
      CPU6_ALUCONTROL_OR  = 4'd3,
      CPU6_ALUCONTROL_SLT = 4'd4,
      CPU6_ALUCONTROL_SLL = 4'd5,
      CPU6_ALUCONTROL_SRL = 4'd6,
      CPU6_ALUCONTROL_SRA = 4'd7
   } alucontrol_e;

   typedef enum logic [0:0] {
      CPU6_EXU_STATE_IDLE  = 1'b0,
      CPU6_EXU_STATE_SHIFT = 1'b1
   } exu_state_e;

   // True for the iterative (multi-cycle) shift operations.
   function automatic logic is_shift_op(input logic [CPU6_ALUCONTROL_SIZE-1:0] code);
      logic shift_s;
      case (code)
         CPU6_ALUCONTROL_SLL,
         CPU6_ALUCONTROL_SRL,
         CPU6_ALUCONTROL_SRA: shift_s = 1'b1;
         default:             shift_s = 1'b0;
      endcase
      return shift_s;
   endfunction

   // Zero flag of a result word.
   function automatic logic is_zero(input logic [XLEN-1:0] value);
      return (value == {XLEN{1'b0}});
   endfunction

endpackage

// File: rtl/cpu6_alu_exu_if.sv
// Operand/result handshake bundle between the ID/EX latch, the execute ALU and EX/MEM.
interface cpu6_alu_exu_if;
   import cpu6_alu_exu_pkg::*;

   logic                            in_valid;
   logic                            in_ready;
   logic [XLEN-1:0]                 a;
   logic [XLEN-1:0]                 b;
   logic [CPU6_ALUCONTROL_SIZE-1:0] alucontrol;
   logic                            out_valid;
   logic                            out_ready;
   logic [XLEN-1:0]                 result;
   logic                            zero;

   // Pipeline side: supplies operands and consumes results.
   modport master (
      output in_valid, a, b, alucontrol, out_ready,
      input  in_ready, out_valid, result, zero
   );

   // ALU side.
   modport slave (
      input  in_valid, a, b, alucontrol, out_ready,
      output in_ready, out_valid, result, zero
   );

endinterface

// File: rtl/cpu6_alu_comb.sv
// Pure combinational single-cycle ALU; shift codes and unknown codes yield zero here.
module cpu6_alu_comb
   import cpu6_alu_exu_pkg::*;
(
   input  logic [XLEN-1:0]                 a,
   input  logic [XLEN-1:0]                 b,
   input  logic [CPU6_ALUCONTROL_SIZE-1:0] alucontrol,
   output logic [XLEN-1:0]                 result
);

   // Select the single-cycle operation; SLT is an unsigned compare (SLTU/SLTIU mapping).
   always_comb begin
      result = {XLEN{1'b0}};
      case (alucontrol)
         CPU6_ALUCONTROL_ADD: result = a + b;
         CPU6_ALUCONTROL_SUB: result = a - b;
         CPU6_ALUCONTROL_AND: result = a & b;
         CPU6_ALUCONTROL_OR:  result = a | b;
         CPU6_ALUCONTROL_SLT: result = {{(XLEN-1){1'b0}}, (a < b)};
         default:             result = {XLEN{1'b0}};
      endcase
   end

endmodule

// File: rtl/cpu6_alu_exu.sv
// cpu6 execute-stage ALU: one-cycle arithmetic/logic, iterative 1-bit-per-cycle shifts,
// registered result/zero with valid/ready hold and a flush for branch redirect.
module cpu6_alu_exu
   import cpu6_alu_exu_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   cpu6_alu_exu_if.slave bus
);

   exu_state_e                      state_r;
   logic [XLEN-1:0]                 work_r;
   logic [SHAMT_W-1:0]              cnt_r;
   logic [CPU6_ALUCONTROL_SIZE-1:0] op_r;
   logic [XLEN-1:0]                 result_r;
   logic                            zero_r;
   logic                            out_valid_r;

   logic                            in_ready_s;
   logic                            accept_s;
   logic [XLEN-1:0]                 comb_result_s;
   logic [XLEN-1:0]                 shift_next_s;

   cpu6_alu_comb u_alu_comb (
      .a          (bus.a),
      .b          (bus.b),
      .alucontrol (bus.alucontrol),
      .result     (comb_result_s)
   );

   // Accept only when idle, not killed, and the output slot is empty or draining this cycle.
   always_comb begin
      in_ready_s = 1'b0;
      if (!reset && !flush && (state_r == CPU6_EXU_STATE_IDLE) &&
          (!out_valid_r || bus.out_ready)) begin
         in_ready_s = 1'b1;
      end else begin
         in_ready_s = 1'b0;
      end
   end

   assign accept_s = bus.in_valid & in_ready_s;

   // One-bit step of the latched shift operation; SRA replicates the sign bit.
   always_comb begin
      shift_next_s = work_r;
      case (op_r)
         CPU6_ALUCONTROL_SLL: shift_next_s = {work_r[XLEN-2:0], 1'b0};
         CPU6_ALUCONTROL_SRL: shift_next_s = {1'b0, work_r[XLEN-1:1]};
         CPU6_ALUCONTROL_SRA: shift_next_s = {work_r[XLEN-1], work_r[XLEN-1:1]};
         default:             shift_next_s = work_r;
      endcase
   end

   // Control FSM, shift datapath and output register; flush beats accept and completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= CPU6_EXU_STATE_IDLE;
         work_r      <= {XLEN{1'b0}};
         cnt_r       <= {SHAMT_W{1'b0}};
         op_r        <= {CPU6_ALUCONTROL_SIZE{1'b0}};
         result_r    <= {XLEN{1'b0}};
         zero_r      <= 1'b1;
         out_valid_r <= 1'b0;
      end else if (flush) begin
         state_r     <= CPU6_EXU_STATE_IDLE;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            CPU6_EXU_STATE_IDLE: begin
               if (accept_s && is_shift_op(bus.alucontrol)) begin
                  work_r      <= bus.a;
                  cnt_r       <= bus.b[SHAMT_W-1:0];
                  op_r        <= bus.alucontrol;
                  out_valid_r <= 1'b0;
                  state_r     <= CPU6_EXU_STATE_SHIFT;
               end else if (accept_s) begin
                  result_r    <= comb_result_s;
                  zero_r      <= is_zero(comb_result_s);
                  out_valid_r <= 1'b1;
               end else if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
               end
            end
            CPU6_EXU_STATE_SHIFT: begin
               if (cnt_r != {SHAMT_W{1'b0}}) begin
                  work_r <= shift_next_s;
                  cnt_r  <= cnt_r - SHAMT_W'(1);
               end else begin
                  result_r    <= work_r;
                  zero_r      <= is_zero(work_r);
                  out_valid_r <= 1'b1;
                  state_r     <= CPU6_EXU_STATE_IDLE;
               end
            end
            default: begin
               state_r     <= CPU6_EXU_STATE_IDLE;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
   assign bus.zero      = zero_r;

endmodule
